// File: rtl/if_fetch_pkg.sv
// Shared CPU defines for the fetch stage: default address width, reset PC,
// instruction width, output buffer depth and fetch FSM state encodings.
package if_fetch_pkg;

    localparam int unsigned XLEN_DEFAULT      = 64;
    localparam logic [63:0] RESET_PC_DEFAULT  = 64'h0000_0000_8000_0000;
    localparam int unsigned ILEN              = 32;
    localparam int unsigned BUF_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, inst} entries for decode.
// Ports:
//   clock, reset_n   : clock, synchronous active-low reset
//   flush            : empties the FIFO; overrides push and pop
//   push, push_data  : write an entry (ignored when full)
//   pop              : remove the head entry (ignored when empty)
//   head             : head entry (registered storage)
//   valid            : FIFO not empty
//   count            : number of stored entries
module fetch_buf #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push & (count < CNT_W'(DEPTH)) & ~flush;
    assign do_pop  = pop & (count != '0) & ~flush;
    assign head    = mem[rd_ptr];
    assign valid   = (count != '0);

    // Storage, pointers and occupancy
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one outstanding fetch at a time to the
// instruction memory, buffers returned words for decode, and handles
// redirects by flushing the buffer and discarding stale responses.
// Ports:
//   clock, reset_n                       : clock, synchronous active-low reset
//   imem_req_valid/ready/addr            : fetch request channel (word aligned)
//   imem_rsp_valid/data                  : in-order one-cycle response pulse
//   redirect_valid/pc                    : branch/jump/trap redirect
//   out_valid/ready, out_pc, out_inst    : instruction stream to decode
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst
);

    localparam int unsigned     CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam int unsigned     ENT_W      = XLEN + ILEN;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    fetch_state_e     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic             drop;

    logic             fire;
    logic             push;
    logic             pop;
    logic             room_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [XLEN-1:0]  redirect_tgt;
    logic [ENT_W-1:0] head;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign fire         = imem_req_valid & imem_req_ready;
    // Responses that belong to a redirected-away stream never reach the buffer
    assign push         = (state == ST_WAIT) & imem_rsp_valid & ~drop & ~redirect_valid;
    assign pop          = out_valid & out_ready;

    // Occupancy after this edge; decides whether the next request may be raised
    always_comb begin
        count_next = count;
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop & ~redirect_valid);
        end
    end

    assign room_next = (count_next < CNT_W'(BUF_DEPTH));

    // Fetch FSM with registered request outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC & ALIGN_MASK;
            req_pc         <= '0;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state          <= ST_REQ;
                    imem_req_valid <= room_next;
                    imem_req_addr  <= redirect_valid ? redirect_tgt : pc;
                    if (redirect_valid) begin
                        pc <= redirect_tgt;
                    end
                end
                ST_REQ: begin
                    if (fire) begin
                        state          <= ST_WAIT;
                        req_pc         <= imem_req_addr;
                        imem_req_valid <= 1'b0;
                        drop           <= drop | redirect_valid;
                        // A stale request must not advance the redirected pc
                        if (redirect_valid) begin
                            pc <= redirect_tgt;
                        end else if (!drop) begin
                            pc <= pc + PC_STEP;
                        end
                    end else begin
                        if (redirect_valid) begin
                            pc   <= redirect_tgt;
                            drop <= drop | imem_req_valid;
                        end
                        // A raised request is frozen until it fires
                        if (!imem_req_valid) begin
                            imem_req_valid <= room_next;
                            imem_req_addr  <= redirect_valid ? redirect_tgt : pc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_tgt;
                    end
                    if (imem_rsp_valid) begin
                        // The outstanding response has arrived, so nothing is left to drop
                        state          <= ST_REQ;
                        drop           <= 1'b0;
                        imem_req_valid <= room_next;
                        imem_req_addr  <= redirect_valid ? redirect_tgt : pc;
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    fetch_buf #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({req_pc, imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .valid     (out_valid),
        .count     (count)
    );

    assign out_pc   = head[ENT_W-1:ILEN];
    assign out_inst = head[ILEN-1:0];

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 64, address/PC width.
REQ-002 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, output buffer entries (fixed at 2 in this revision).
REQ-004 SHALL have ports:
- clock in 1: single clock, all state on rising edge.
- reset_n in 1: synchronous, active-low reset.
- imem_req_valid out 1: fetch request valid.
- imem_req_ready in 1: memory accepts request.
- imem_req_addr out XLEN: fetch address, bits [1:0] always 0.
- imem_rsp_valid in 1: instruction returned (one-cycle pulse, in request order).
- imem_rsp_data in 32: instruction word.
- redirect_valid in 1: branch/jump/trap redirect.
- redirect_pc in XLEN: new PC.
- out_valid out 1: instruction available to decode.
- out_ready in 1: decode accepts.
- out_pc out XLEN: PC of out_inst.
- out_inst out 32: instruction word to decoder key/lut muxes.

Function
REQ-005 SHALL implement FSM IDLE -> REQ -> WAIT -> REQ. IDLE lasts exactly one cycle after reset release.
REQ-006 In REQ, imem_req_valid SHALL be 1 iff buffer count < 2; imem_req_addr = pc.
REQ-007 On request fire (valid & ready), SHALL latch req_pc = pc, set pc = pc + 4, enter WAIT.
REQ-008 Once asserted, imem_req_valid and imem_req_addr SHALL stay stable until fire, including across a redirect.
REQ-009 At most one request SHALL be outstanding; no request in WAIT.
REQ-010 In WAIT, on imem_rsp_valid, SHALL push {req_pc, imem_rsp_data} unless drop is set, then return to REQ.
REQ-011 Response-to-out_valid latency SHALL be 1 cycle (registered buffer).
REQ-012 Buffer SHALL be FIFO. out_pc/out_inst = head entry. out_valid = count != 0. Pop on out_valid & out_ready.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged. A push at count 2 SHALL be impossible by REQ-006.
REQ-014 redirect_valid SHALL have highest priority:
- pc = {redirect_pc[XLEN-1:2], 2'b00}.
- buffer flushed (count = 0).
- pop in the same cycle ignored.
REQ-015 Drop flag on redirect:
- If in WAIT, or REQ with imem_req_valid & !imem_req_ready, SHALL set drop.
- Request firing in the redirect cycle SHALL also set drop.
- A response arriving in the redirect cycle SHALL be discarded.
REQ-016 A dropped response SHALL clear drop and not push.
REQ-017 A pending unfired request with drop set SHALL still complete, then its response is dropped. Fetch then resumes at the redirected pc.
REQ-018 Back-to-back redirects SHALL take the last target; drop stays set until the outstanding response arrives.
REQ-019 pc SHALL wrap modulo 2^XLEN without error.

Reset
REQ-020 While reset_n = 0 at a clock edge, SHALL set:
- state = IDLE, pc = RESET_PC, count = 0, drop = 0.
- imem_req_valid = 0, out_valid = 0, out_pc = 0, out_inst = 0.
REQ-021 Reset mid-request SHALL abandon outstanding transactions. The memory side is reset by the same reset_n.

Structure
REQ-022 XLEN, RESET_PC, the 32-bit instruction width and the FSM state encodings SHALL live in the shared CPU defines package.
REQ-023 The buffer SHALL be sub-module fetch_buf: 2-entry synchronous FIFO with flush input and count output.
REQ-024 Target size is 150-300 lines RTL.

Verification
REQ-025 Reset release, imem_req_ready = 1, 1-cycle memory latency -> first imem_req_addr = 0x80000000. out_pc sequence 0x80000000, 0x80000004, 0x80000008, with out_inst matching memory.
REQ-026 out_ready = 0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid = 0. Release -> in-order drain, no loss or duplication.
REQ-027 redirect_valid with redirect_pc = 0x80001003 while in WAIT -> in-flight response dropped. Next request addr = 0x80001000, next out_pc = 0x80001000.
REQ-028 imem_req_ready = 0 for 5 cycles with redirect in cycle 2 -> imem_req_addr unchanged until fire. That response is dropped; the following request is to the target.
REQ-029 Redirect and imem_rsp_valid in the same cycle, with count 1 and out_ready = 1 -> buffer empty next cycle, response discarded.
REQ-030 reset_n = 0 during WAIT -> all outputs at reset values next cycle. Fetch restarts at 0x80000000 after IDLE.
